bram_stream_reader: RTL and testbench

Read-side DMA for the Sobel edge-detector output buffer. After the detector reports completion, this block fetches `i_num_cnt` pixels from BRAM1's port 0 in ascending address order and presents them on a valid/ready pixel stream with a last-pixel flag. It sits between the BRAM1 host port and the downstream consumer (display/UART/AXI-stream bridge), replacing the manual BRAM1 readout sequence.

---
 rtl/bram_stream_reader_if.sv | 30 +++
 rtl/bram_stream_reader.sv | 119 +++++++++++
 tb/tb_bram_stream_reader.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// Bus bundle for the BRAM1 read-side DMA: control/status, BRAM port 0 and the pixel stream.
// The slave modport is the reader; the master modport is the host/BRAM/consumer side.
interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
);
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_num_cnt;
    logic                  o_idle;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_ce;
    logic                  o_we;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [DATA_WIDTH-1:0] i_q;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_last;
    logic                  i_ready;

    modport slave (
        input  i_start, i_num_cnt, i_q, i_ready,
        output o_idle, o_busy, o_done, o_ce, o_we, o_addr, o_valid, o_data, o_last
    );

    modport master (
        output i_start, i_num_cnt, i_q, i_ready,
        input  o_idle, o_busy, o_done, o_ce, o_we, o_addr, o_valid, o_data, o_last
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Reads N pixels from BRAM1 port 0 in ascending order and streams them out over valid/ready
// with a last flag, through a 2-entry skid FIFO that absorbs the 1-cycle BRAM read latency.
//
// state  | meaning
// IDLE   | waiting for i_start; count latched on accept
// RUN    | issuing reads and delivering beats until the last beat is accepted
// DONE   | one-cycle completion pulse, then back to IDLE
module bram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    bram_stream_reader_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt, r_issue, r_accept, r_addr;
    logic                  r_inflight, r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic                  r_fifo_last [2];
    logic                  r_rd_ptr, r_wr_ptr;
    logic [1:0]            r_fcount;

    logic                  w_valid, w_pop, w_issue, w_start_ok;
    logic                  w_idle, w_busy, w_done;
    logic [2:0]            w_occ;

    assign w_valid = (r_fcount != 2'd0);
    assign w_pop   = w_valid & bus.i_ready;
    // Occupancy after this cycle's pop; i_ready reaches o_ce combinationally through here,
    // a deliberate path that the synthesis constraints must cover.
    assign w_occ   = {1'b0, r_fcount} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == S_RUN) && (r_issue < r_cnt) && (w_occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idle      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idle = 1'b1;
                if (bus.i_start) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = (bus.i_num_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_pop && (r_accept == r_cnt - ONE)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt           <= '0;
            r_issue         <= '0;
            r_accept        <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_wr_ptr        <= 1'b0;
            r_fcount        <= 2'd0;
            for (int k = 0; k < 2; k++) begin
                r_fifo_data[k] <= '0;
                r_fifo_last[k] <= 1'b0;
            end
        end else begin
            if (w_start_ok) begin
                r_cnt    <= bus.i_num_cnt;
                r_issue  <= '0;
                r_accept <= '0;
            end
            if (w_issue) begin
                r_issue <= r_issue + ONE;
                r_addr  <= r_issue;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_issue == r_cnt - ONE);
            if (r_inflight) begin
                r_fifo_data[r_wr_ptr] <= bus.i_q;
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_accept <= r_accept + ONE;
            end
            r_fcount <= r_fcount + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    assign bus.o_idle  = w_idle;
    assign bus.o_busy  = w_busy;
    assign bus.o_done  = w_done;
    assign bus.o_ce    = w_issue;
    assign bus.o_we    = 1'b0;
    assign bus.o_addr  = w_issue ? r_issue : r_addr;
    assign bus.o_valid = w_valid;
    assign bus.o_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign bus.o_last  = w_valid & r_fifo_last[r_rd_ptr];
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a 16-bit-address instance for the main scenarios and a
// 4-bit-address instance for the maximum-count case, each fed by a 1-cycle-latency BRAM model.
module tb_bram_stream_reader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) b();
    bram_stream_reader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4))  b4();

    bram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(16)) dut  (.clk(clk), .rst(rst), .bus(b));
    bram_stream_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(b4));

    logic [7:0] mem  [256];
    logic [7:0] mem4 [16];

    always @(posedge clk) if (b.o_ce)  b.i_q  <= mem[b.o_addr[7:0]];
    always @(posedge clk) if (b4.o_ce) b4.i_q <= mem4[b4.o_addr];

    int n_checks = 0;
    int n_fail   = 0;

    int obs_beats[$];
    int obs_last_idx[$];
    int obs_first, obs_last_cyc, obs_done, obs_idle;
    int obs_ce, obs_valid, obs_unstable, obs_addr_err, obs_occ_err, obs_timeout;

    // Drives one run (start in cycle 0) and records what the stream and BRAM port did.
    task automatic run_stream(input int sel, input int n, input int mode, input int extra_cyc,
                              input int stop_cyc);
        int c, acc, nc, v_addr;
        bit fin, pv_stall, st;
        logic [15:0] lfsr;
        logic [7:0] pv_data, v_data;
        logic pv_last, v_valid, v_ready, v_last, v_ce, v_done, v_idle;
        obs_beats.delete();
        obs_last_idx.delete();
        obs_first = -1; obs_last_cyc = -1; obs_done = -1; obs_idle = -1;
        obs_ce = 0; obs_valid = 0; obs_unstable = 0; obs_addr_err = 0; obs_occ_err = 0;
        obs_timeout = 0;
        c = 0; acc = 0; fin = 0; pv_stall = 0; pv_data = 0; pv_last = 0; lfsr = 16'hACE1;
        while (!fin) begin
            @(posedge clk); #1;
            case (mode)
                0: v_ready = 1'b1;
                1: v_ready = ((c % 4) == 0) || ((c % 4) == 3);
                default: begin
                    v_ready = lfsr[0] | lfsr[5];
                    lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                end
            endcase
            st = (c == 0) || (c == extra_cyc);
            nc = (extra_cyc > 0 && c >= extra_cyc) ? 3 : n;
            if (sel == 0) begin
                b.i_start = st; b.i_num_cnt = nc[15:0]; b.i_ready = v_ready;
            end else begin
                b4.i_start = st; b4.i_num_cnt = nc[3:0]; b4.i_ready = v_ready;
            end
            @(negedge clk);
            if (sel == 0) begin
                v_valid = b.o_valid; v_data = b.o_data; v_last = b.o_last; v_ce = b.o_ce;
                v_done = b.o_done; v_idle = b.o_idle; v_addr = int'(b.o_addr);
            end else begin
                v_valid = b4.o_valid; v_data = b4.o_data; v_last = b4.o_last; v_ce = b4.o_ce;
                v_done = b4.o_done; v_idle = b4.o_idle; v_addr = int'(b4.o_addr);
            end
            if ((obs_ce - acc) > 2) obs_occ_err++;
            if (pv_stall && (!v_valid || v_data !== pv_data || v_last !== pv_last)) obs_unstable++;
            if (v_ce) begin
                if (v_addr != obs_ce) obs_addr_err++;
                obs_ce++;
            end
            if (v_valid) obs_valid++;
            if (v_valid && v_ready) begin
                if (obs_first < 0) obs_first = c;
                if (v_last) begin
                    obs_last_idx.push_back(obs_beats.size());
                    obs_last_cyc = c;
                end
                obs_beats.push_back(int'(v_data));
                acc++;
            end
            pv_stall = v_valid && !v_ready; pv_data = v_data; pv_last = v_last;
            if (v_done && obs_done < 0) obs_done = c;
            if (obs_done >= 0 && v_idle && obs_idle < 0) begin
                obs_idle = c;
                fin = 1;
            end
            c++;
            if (stop_cyc > 0 && c >= stop_cyc) fin = 1;
            if (c >= 400) begin
                obs_timeout = 1;
                fin = 1;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (b.o_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle got %b exp 1", b.o_idle); end
        n_checks++; if (b.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", b.o_busy); end
        n_checks++; if (b.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", b.o_done); end
        n_checks++; if (b.o_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got %b exp 0", b.o_ce); end
        n_checks++; if (b.o_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", b.o_we); end
        n_checks++; if (b.o_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", b.o_addr); end
        n_checks++; if (b.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", b.o_valid); end
        n_checks++; if (b.o_data !== 8'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", b.o_data); end
        n_checks++; if (b.o_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b exp 0", b.o_last); end
    endtask

    task automatic test_basic();
        run_stream(0, 25, 0, -1, 0);
        n_checks++; if (obs_timeout !== 0) begin n_fail++; $display("FAIL basic_timeout got %0d exp 0", obs_timeout); end
        n_checks++; if (obs_beats.size() !== 25) begin n_fail++; $display("FAIL basic_beats got %0d exp 25", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size(); k++) begin
            n_checks++; if (obs_beats[k] !== k) begin n_fail++; $display("FAIL basic_data[%0d] got %0d exp %0d", k, obs_beats[k], k); end
        end
        n_checks++; if (obs_first !== 3) begin n_fail++; $display("FAIL basic_first_cyc got %0d exp 3", obs_first); end
        n_checks++; if (obs_last_cyc !== 27) begin n_fail++; $display("FAIL basic_last_cyc got %0d exp 27", obs_last_cyc); end
        n_checks++; if (obs_last_idx.size() !== 1) begin n_fail++; $display("FAIL basic_last_count got %0d exp 1", obs_last_idx.size()); end
        else begin
            n_checks++; if (obs_last_idx[0] !== 24) begin n_fail++; $display("FAIL basic_last_idx got %0d exp 24", obs_last_idx[0]); end
        end
        n_checks++; if (obs_done !== 28) begin n_fail++; $display("FAIL basic_done_cyc got %0d exp 28", obs_done); end
        n_checks++; if (obs_idle !== 29) begin n_fail++; $display("FAIL basic_idle_cyc got %0d exp 29", obs_idle); end
        n_checks++; if (obs_ce !== 25) begin n_fail++; $display("FAIL basic_ce_cycles got %0d exp 25", obs_ce); end
        n_checks++; if (obs_addr_err !== 0) begin n_fail++; $display("FAIL basic_addr_order got %0d errors exp 0", obs_addr_err); end
    endtask

    task automatic test_backpressure();
        for (int m = 1; m <= 2; m++) begin
            run_stream(0, 25, m, -1, 0);
            n_checks++; if (obs_timeout !== 0) begin n_fail++; $display("FAIL bp%0d_timeout got %0d exp 0", m, obs_timeout); end
            n_checks++; if (obs_beats.size() !== 25) begin n_fail++; $display("FAIL bp%0d_beats got %0d exp 25", m, obs_beats.size()); end
            for (int k = 0; k < obs_beats.size(); k++) begin
                n_checks++; if (obs_beats[k] !== k) begin n_fail++; $display("FAIL bp%0d_data[%0d] got %0d exp %0d", m, k, obs_beats[k], k); end
            end
            n_checks++; if (obs_unstable !== 0) begin n_fail++; $display("FAIL bp%0d_stall_stable got %0d changes exp 0", m, obs_unstable); end
            n_checks++; if (obs_occ_err !== 0) begin n_fail++; $display("FAIL bp%0d_outstanding got %0d overflows exp 0", m, obs_occ_err); end
            n_checks++; if (obs_ce !== 25) begin n_fail++; $display("FAIL bp%0d_ce_cycles got %0d exp 25", m, obs_ce); end
            n_checks++; if (obs_addr_err !== 0) begin n_fail++; $display("FAIL bp%0d_addr_order got %0d errors exp 0", m, obs_addr_err); end
            n_checks++; if (obs_last_idx.size() !== 1 || obs_last_idx[0] !== 24) begin n_fail++; $display("FAIL bp%0d_last got %0d flags exp 1 on beat 24", m, obs_last_idx.size()); end
        end
    endtask

    task automatic test_zero_and_single();
        run_stream(0, 0, 0, -1, 0);
        n_checks++; if (obs_done !== 1) begin n_fail++; $display("FAIL zero_done_cyc got %0d exp 1", obs_done); end
        n_checks++; if (obs_idle !== 2) begin n_fail++; $display("FAIL zero_idle_cyc got %0d exp 2", obs_idle); end
        n_checks++; if (obs_ce !== 0) begin n_fail++; $display("FAIL zero_ce_cycles got %0d exp 0", obs_ce); end
        n_checks++; if (obs_valid !== 0) begin n_fail++; $display("FAIL zero_valid_cycles got %0d exp 0", obs_valid); end
        mem[0] = 8'hFF;
        run_stream(0, 1, 0, -1, 0);
        mem[0] = 8'h00;
        n_checks++; if (obs_beats.size() !== 1) begin n_fail++; $display("FAIL single_beats got %0d exp 1", obs_beats.size()); end
        else begin
            n_checks++; if (obs_beats[0] !== 255) begin n_fail++; $display("FAIL single_data got %0d exp 255", obs_beats[0]); end
        end
        n_checks++; if (obs_last_cyc !== 3) begin n_fail++; $display("FAIL single_last_cyc got %0d exp 3", obs_last_cyc); end
        n_checks++; if (obs_done !== 4) begin n_fail++; $display("FAIL single_done_cyc got %0d exp 4", obs_done); end
    endtask

    task automatic test_restart_ignored();
        run_stream(0, 25, 0, 10, 0);
        n_checks++; if (obs_beats.size() !== 25) begin n_fail++; $display("FAIL restart_beats got %0d exp 25", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size(); k++) begin
            n_checks++; if (obs_beats[k] !== k) begin n_fail++; $display("FAIL restart_data[%0d] got %0d exp %0d", k, obs_beats[k], k); end
        end
        n_checks++; if (obs_done !== 28) begin n_fail++; $display("FAIL restart_done_cyc got %0d exp 28", obs_done); end
        n_checks++; if (obs_ce !== 25) begin n_fail++; $display("FAIL restart_ce_cycles got %0d exp 25", obs_ce); end
    endtask

    task automatic test_mid_reset();
        run_stream(0, 25, 0, -1, 12);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (b.o_idle !== 1'b1 || b.o_busy !== 1'b0 || b.o_done !== 1'b0) begin n_fail++; $display("FAIL midrst_status got idle=%b busy=%b done=%b exp 1/0/0", b.o_idle, b.o_busy, b.o_done); end
        n_checks++; if (b.o_ce !== 1'b0 || b.o_we !== 1'b0 || b.o_addr !== 16'h0) begin n_fail++; $display("FAIL midrst_bram got ce=%b we=%b addr=%h exp 0/0/0", b.o_ce, b.o_we, b.o_addr); end
        n_checks++; if (b.o_valid !== 1'b0 || b.o_data !== 8'h0 || b.o_last !== 1'b0) begin n_fail++; $display("FAIL midrst_stream got valid=%b data=%h last=%b exp 0/0/0", b.o_valid, b.o_data, b.o_last); end
        @(posedge clk); #1;
        rst = 1'b0;
        b.i_start = 1'b0;
        @(negedge clk);
        n_checks++; if (b.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_late_q got valid=%b exp 0", b.o_valid); end
        run_stream(0, 5, 0, -1, 0);
        n_checks++; if (obs_beats.size() !== 5) begin n_fail++; $display("FAIL midrst_beats got %0d exp 5", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size(); k++) begin
            n_checks++; if (obs_beats[k] !== k) begin n_fail++; $display("FAIL midrst_data[%0d] got %0d exp %0d", k, obs_beats[k], k); end
        end
        n_checks++; if (obs_first !== 3) begin n_fail++; $display("FAIL midrst_first_cyc got %0d exp 3", obs_first); end
        n_checks++; if (obs_done !== 8) begin n_fail++; $display("FAIL midrst_done_cyc got %0d exp 8", obs_done); end
    endtask

    task automatic test_max_count();
        run_stream(1, 15, 0, -1, 0);
        n_checks++; if (obs_timeout !== 0) begin n_fail++; $display("FAIL max_timeout got %0d exp 0", obs_timeout); end
        n_checks++; if (obs_beats.size() !== 15) begin n_fail++; $display("FAIL max_beats got %0d exp 15", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size(); k++) begin
            n_checks++; if (obs_beats[k] !== 160 + k) begin n_fail++; $display("FAIL max_data[%0d] got %0d exp %0d", k, obs_beats[k], 160 + k); end
        end
        n_checks++; if (obs_ce !== 15) begin n_fail++; $display("FAIL max_ce_cycles got %0d exp 15", obs_ce); end
        n_checks++; if (obs_addr_err !== 0) begin n_fail++; $display("FAIL max_addr_order got %0d errors exp 0", obs_addr_err); end
        n_checks++; if (obs_last_idx.size() !== 1 || obs_last_idx[0] !== 14) begin n_fail++; $display("FAIL max_last got %0d flags exp 1 on beat 14", obs_last_idx.size()); end
        n_checks++; if (obs_done !== 18) begin n_fail++; $display("FAIL max_done_cyc got %0d exp 18", obs_done); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i[7:0];
        for (int i = 0; i < 16; i++) mem4[i] = 8'hA0 + i[7:0];
        b.i_start = 1'b0;  b.i_num_cnt = '0;  b.i_ready = 1'b0;
        b4.i_start = 1'b0; b4.i_num_cnt = '0; b4.i_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        test_basic();
        test_backpressure();
        test_zero_and_single();
        test_restart_ignored();
        test_mid_reset();
        test_max_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
